// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the data stage.
// Data side has priority. A saturating starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
    parameter int N            = 64,
    parameter int STARVE_LIMIT = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         if_req,
    input  logic [N-1:0] if_addr,
    output logic [31:0]  if_rdata,
    output logic         if_valid,
    output logic         if_stall,
    input  logic         dm_readEnable,
    input  logic         dm_writeEnable,
    input  logic [N-1:0] dm_addr,
    input  logic [N-1:0] dm_wdata,
    output logic [N-1:0] dm_rdata,
    output logic         dm_valid,
    output logic         dm_stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_e;

    state_e        state, nextState;
    logic [CW-1:0] starveCnt;
    logic          ifEligible, dmEligible;
    logic          grantIf, grantDm;

    // A requester whose valid is high is still holding its completed request.
    assign ifEligible = if_req & ~if_valid;
    assign dmEligible = (dm_readEnable | dm_writeEnable) & ~dm_valid;

    assign mem_req  = (state != IDLE);
    assign if_stall = if_req & ~if_valid;
    assign dm_stall = (dm_readEnable | dm_writeEnable) & ~dm_valid;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        grantIf   = 1'b0;
        grantDm   = 1'b0;
        nextState = state;
        case (state)
            IDLE: begin
                if (ifEligible && starveCnt == CW'(STARVE_LIMIT)) grantIf = 1'b1;
                else if (dmEligible)                              grantDm = 1'b1;
                else if (ifEligible)                              grantIf = 1'b1;
                if (grantIf)      nextState = IF_BUSY;
                else if (grantDm) nextState = DM_BUSY;
            end
            IF_BUSY, DM_BUSY: if (mem_ready) nextState = IDLE;
            default:          nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            starveCnt <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_rdata  <= '0;
            dm_valid  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state    <= nextState;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;

            if (grantIf) begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                starveCnt <= '0;
            end

            if (grantDm) begin
                mem_we    <= dm_writeEnable;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                if (if_req && starveCnt != CW'(STARVE_LIMIT))
                    starveCnt <= starveCnt + CW'(1);
            end

            if (state == IF_BUSY && mem_ready) begin
                if_valid <= 1'b1;
                if_rdata <= mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
            end

            if (state == DM_BUSY && mem_ready) begin
                dm_valid <= 1'b1;
                if (!mem_we) dm_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter.
// Requesters and memory are driven from a transaction-level reference model, and the DUT outputs are compared every cycle.
module tb_mem_port_arbiter;

    localparam int N   = 64;
    localparam int LIM = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         if_req;
    logic [N-1:0] if_addr;
    logic [31:0]  if_rdata;
    logic         if_valid, if_stall;
    logic         dm_readEnable, dm_writeEnable;
    logic [N-1:0] dm_addr, dm_wdata, dm_rdata;
    logic         dm_valid, dm_stall;
    logic         mem_req, mem_we;
    logic [N-1:0] mem_addr, mem_wdata, mem_rdata;
    logic         mem_ready;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N(N), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .dm_readEnable(dm_readEnable), .dm_writeEnable(dm_writeEnable),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int vecCnt = 0;
    int errCnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one outstanding access, its owner, and the completion results.
    bit          mBusy, mOwnerIf, mWe, mIfValid, mDmValid;
    logic [63:0] mAddr, mWdata, mDmRdata;
    logic [31:0] mIfRdata;
    int          mStarve;

    // Stimulus state: whether each requester has a request outstanding, and memory wait.
    bit ifActive, dmActive, memStarted;
    int memWait;

    task automatic modelReset();
        mBusy = 0; mOwnerIf = 0; mWe = 0; mIfValid = 0; mDmValid = 0;
        mAddr = '0; mWdata = '0; mDmRdata = '0; mIfRdata = '0; mStarve = 0;
    endtask

    task automatic modelStep();
        bit nIfV, nDmV, ifOk, dmOk;
        int winner;  // 0 none, 1 fetch, 2 data
        nIfV = 0; nDmV = 0; winner = 0;
        if (!mBusy) begin
            ifOk = if_req && !mIfValid;
            dmOk = (dm_readEnable || dm_writeEnable) && !mDmValid;
            if (ifOk && mStarve == LIM) winner = 1;
            else if (dmOk)              winner = 2;
            else if (ifOk)              winner = 1;
            if (winner == 1) begin
                mBusy = 1; mOwnerIf = 1; mWe = 0; mAddr = if_addr; mStarve = 0;
            end else if (winner == 2) begin
                mBusy = 1; mOwnerIf = 0; mWe = dm_writeEnable;
                mAddr = dm_addr; mWdata = dm_wdata;
                if (if_req) mStarve = (mStarve + 1 > LIM) ? LIM : mStarve + 1;
            end
        end else if (mem_ready) begin
            mBusy = 0;
            if (mOwnerIf) begin
                nIfV = 1;
                mIfRdata = 32'(mem_rdata >> (mAddr[2] ? 32 : 0));
            end else begin
                nDmV = 1;
                if (!mWe) mDmRdata = mem_rdata;
            end
        end
        mIfValid = nIfV;
        mDmValid = nDmV;
    endtask

    task automatic driveInputs();
        int k;
        if (ifActive && mIfValid) begin
            ifActive = 0;
            if_req   = 1'($urandom_range(0, 1));  // may keep the stale request up for its valid cycle
        end else if (!ifActive) begin
            if_addr = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) begin
                ifActive = 1; if_req = 1'b1;
            end else begin
                if_req = 1'b0;
            end
        end

        if (dmActive && mDmValid) begin
            dmActive = 0;
            if ($urandom_range(0, 1) == 0) begin
                dm_readEnable = 1'b0; dm_writeEnable = 1'b0;
            end
        end else if (!dmActive) begin
            dm_addr  = {$urandom, $urandom};
            dm_wdata = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) begin
                k = $urandom_range(0, 2);
                dmActive = 1;
                dm_readEnable  = (k != 1);
                dm_writeEnable = (k != 0);
            end else begin
                dm_readEnable = 1'b0; dm_writeEnable = 1'b0;
            end
        end

        mem_rdata = {$urandom, $urandom};
        if (mBusy) begin
            if (!memStarted) begin
                memStarted = 1;
                memWait = $urandom_range(0, 2);
            end
            mem_ready = (memWait == 0);
            if (memWait > 0) memWait--;
            if (mem_ready) memStarted = 0;
        end else begin
            mem_ready = ($urandom_range(0, 3) == 0);  // stray ready while idle
        end
    endtask

    task automatic checkOutputs();
        check("mem_req",  64'(mem_req),  64'(mBusy));
        check("mem_we",   64'(mem_we),   64'(mWe));
        check("mem_addr", mem_addr, mAddr);
        if (mBusy && !mOwnerIf) check("mem_wdata", mem_wdata, mWdata);
        check("if_valid", 64'(if_valid), 64'(mIfValid));
        check("dm_valid", 64'(dm_valid), 64'(mDmValid));
        check("if_rdata", 64'(if_rdata), 64'(mIfRdata));
        check("dm_rdata", dm_rdata, mDmRdata);
        check("if_stall", 64'(if_stall), 64'(if_req & ~mIfValid));
        check("dm_stall", 64'(dm_stall), 64'((dm_readEnable | dm_writeEnable) & ~mDmValid));
    endtask

    initial begin
        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_readEnable = 1'b0; dm_writeEnable = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        ifActive = 0; dmActive = 0; memStarted = 0; memWait = 0;
        modelReset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutputs();
        check("rst_mem_wdata", mem_wdata, 64'h0);
        reset = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            modelStep();
            #1 driveInputs();
            if (mBusy && $urandom_range(0, 39) == 0) begin
                #2 reset = 1'b0;
                #1;
                check("rst_mem_req",  64'(mem_req),  64'h0);
                check("rst_if_valid", 64'(if_valid), 64'h0);
                check("rst_dm_valid", 64'(dm_valid), 64'h0);
                check("rst_mem_addr", mem_addr, 64'h0);
                modelReset();
                memStarted = 0;
                mem_ready  = 1'b0;
                @(posedge clk);
                #1 reset = 1'b1;
                driveInputs();
            end
            @(negedge clk);
            checkOutputs();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
